// File: rtl/entradas_pkg.sv
// Shared defaults for the input-conditioning stage.
// Switch and button channel counts plus the debounce window.
package entradas_pkg;

  localparam int CICLOS_ESTABLES_DEF = 1_000_000;
  localparam int N_SWITCH_DEF        = 16;
  localparam int N_BOTON_DEF         = 4;

endpackage

// File: rtl/antirrebote_canal.sv
// One debounced channel: 2-flop synchronizer, stability counter,
// accepted level and a registered rising-edge pulse.
module antirrebote_canal
  import entradas_pkg::*;
#(
  parameter int CICLOS_ESTABLES = CICLOS_ESTABLES_DEF
) (
  input  logic clk_pi,
  input  logic rst_n_pi,
  input  logic raw_pi,
  output logic estable_po,
  output logic pulso_po
);

  localparam int CNT_W = $clog2(CICLOS_ESTABLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CICLOS_ESTABLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             estable;
  logic             estable_d;
  logic             pulso;

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_pi;
      sync2 <= sync1;
    end
  end

  // A single matching cycle throws away the accumulated count.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      cnt     <= '0;
      estable <= 1'b0;
    end else if (sync2 == estable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      estable <= sync2;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      estable_d <= 1'b0;
      pulso     <= 1'b0;
    end else begin
      estable_d <= estable;
      pulso     <= estable & ~estable_d;
    end
  end

  assign estable_po = estable;
  assign pulso_po   = pulso;

endmodule

// File: rtl/antirrebote_entradas.sv
// Synchronizes and debounces all switch and button inputs;
// buttons also get a one-cycle press pulse.
module antirrebote_entradas
  import entradas_pkg::*;
#(
  parameter int N_SWITCH        = N_SWITCH_DEF,
  parameter int N_BOTON         = N_BOTON_DEF,
  parameter int CICLOS_ESTABLES = CICLOS_ESTABLES_DEF
) (
  input  logic                clk_pi,
  input  logic                rst_n_pi,
  input  logic [N_SWITCH-1:0] switch_raw_pi,
  input  logic [N_BOTON-1:0]  boton_raw_pi,
  output logic [N_SWITCH-1:0] switch_po,
  output logic [N_BOTON-1:0]  boton_po,
  output logic [N_BOTON-1:0]  pulso_boton_po
);

  for (genvar i = 0; i < N_SWITCH; i++) begin : g_switch
    antirrebote_canal #(
      .CICLOS_ESTABLES(CICLOS_ESTABLES)
    ) u_canal (
      .clk_pi    (clk_pi),
      .rst_n_pi  (rst_n_pi),
      .raw_pi    (switch_raw_pi[i]),
      .estable_po(switch_po[i]),
      .pulso_po  ()
    );
  end

  for (genvar i = 0; i < N_BOTON; i++) begin : g_boton
    antirrebote_canal #(
      .CICLOS_ESTABLES(CICLOS_ESTABLES)
    ) u_canal (
      .clk_pi    (clk_pi),
      .rst_n_pi  (rst_n_pi),
      .raw_pi    (boton_raw_pi[i]),
      .estable_po(boton_po[i]),
      .pulso_po  (pulso_boton_po[i])
    );
  end

endmodule

// File: doc/antirrebote_entradas.md
# antirrebote_entradas

Input-conditioning stage between the board's raw slide switches / push buttons and the switch-to-LED masking logic. Each of the 16 switch and 4 button inputs is synchronized into the system clock domain and debounced, so downstream logic only sees clean levels. A one-cycle press pulse is also produced per button for future edge-driven consumers. Outputs drive `switch_pi` / `boton_pi` of the LED stage directly.

## Interface
Parameters:
- `N_SWITCH`, 16, number of switch channels
- `N_BOTON`, 4, number of button channels
- `CICLOS_ESTABLES`, 1_000_000, consecutive stable cycles required before accepting a new level (10 ms at 100 MHz); legal range ≥ 2

Ports:
- `clk_pi`  input  1  system clock, all logic on rising edge
- `rst_n_pi`  input  1  reset, asynchronous, active-low
- `switch_raw_pi`  input  N_SWITCH  raw, asynchronous, bouncing switch levels
- `boton_raw_pi`  input  N_BOTON  raw, asynchronous, bouncing button levels (1 = pressed)
- `switch_po`  output  N_SWITCH  debounced switch levels
- `boton_po`  output  N_BOTON  debounced button levels
- `pulso_boton_po`  output  N_BOTON  one-cycle pulse on each debounced 0→1 button transition

## Operation
- All 20 channels identical and fully independent; no cross-channel interaction.
- Per channel: 2-flop synchronizer (`sync1`, `sync2`), counter `cnt` of width `$clog2(CICLOS_ESTABLES)`, stable register `estable`.
- Each edge: if `sync2 == estable` → `cnt <= 0`; else if `cnt == CICLOS_ESTABLES-1` → `estable <= sync2`, `cnt <= 0`; else `cnt <= cnt + 1`.
- Any single cycle with `sync2 == estable` discards accumulated count (glitch rejection); counting restarts from 0 on the next difference.
- Counter never exceeds `CICLOS_ESTABLES-1`; no wrap.
- `switch_po` / `boton_po` = `estable` of the respective channels, registered, no combinational path from raw inputs.
- `pulso_boton_po[i]` = `estable` rose at the previous edge (registered edge detect: `estable & ~estable_d`); exactly one cycle wide; no pulse on release.
- Reset (asynchronous assert, any time, including mid-count): `sync1`, `sync2`, `cnt`, `estable`, `estable_d` all 0 → all outputs 0 immediately. After release, an input already held at 1 is treated as a new level and needs full latency.

## Timing
- Reset values: `switch_po` = 0, `boton_po` = 0, `pulso_boton_po` = 0.
- Latency for a clean level change: output changes at rising edge CICLOS_ESTABLES+2 after the change, counting the first edge that samples the new raw value as edge 1 (edges 1–2 synchronizer, edges 3…N+2 counting).
- `pulso_boton_po` asserts one edge after `boton_po` rises (edge N+3), deasserts the following edge.
- Pulses shorter than CICLOS_ESTABLES synchronized cycles never reach the output.
- Simultaneous changes on several channels resolve independently on the same edge.

## Structure
- Shared package `entradas_pkg`: `CICLOS_ESTABLES_DEF = 1_000_000`, `N_SWITCH_DEF = 16`, `N_BOTON_DEF = 4`.
- One sub-module `antirrebote_canal` (params `CICLOS_ESTABLES`; ports `clk_pi`, `rst_n_pi`, `raw_pi`, `estable_po`, `pulso_po`) instantiated N_SWITCH+N_BOTON times via generate; switch instances leave `pulso_po` unconnected.

## Test plan
Bench runs with `CICLOS_ESTABLES = 4`.
- Reset: hold `rst_n_pi` = 0 with all raw inputs 1 → all outputs 0; release → `switch_po` = 16'hFFFF, `boton_po` = 4'hF at edge 6 after release, `pulso_boton_po` = 4'hF for exactly edge 7 only.
- Clean step: `switch_raw_pi[5]` 0→1 and held → `switch_po[5]` = 1 at edge 6, all other bits unchanged.
- Bounce: `boton_raw_pi[2]` toggles 1,0,1,0 (one cycle each) then held 1 → `boton_po[2]` rises 6 edges after the final rising sample; exactly one `pulso_boton_po[2]` pulse; none during bouncing.
- Glitch: `switch_raw_pi[0]` high for 3 cycles then low → `switch_po[0]` stays 0 throughout.
- Release: `boton_po[1]` = 1, raw drops to 0 and held → `boton_po[1]` = 0 at edge 6, `pulso_boton_po[1]` stays 0.
- Mid-count reset: `switch_raw_pi = 16'hA5A5`, assert `rst_n_pi` at edge 4 → outputs 0 asynchronously; after release, 16'hA5A5 appears at edge 6.
